// File: rtl/alarm_pkg.sv
// Shared types, time constants and the snooze-target helper for the alarm controller.
package alarm_pkg;

    localparam int unsigned TIME_W           = 6;
    localparam int unsigned SUM_W            = TIME_W + 1;
    localparam int unsigned MINUTES_PER_HOUR = 60;
    localparam int unsigned HOURS_PER_DAY    = 24;

    typedef logic [TIME_W-1:0] time_field_t;

    typedef enum logic [1:0] {
        StIdle,
        StRinging,
        StSnoozed
    } alarm_state_e;

    // hh:mm + delta minutes (delta < 60), wrapping at midnight; returns {hour, minute}.
    function automatic logic [2*TIME_W-1:0] time_add(input time_field_t hours,
                                                     input time_field_t minutes,
                                                     input time_field_t delta);
        logic [SUM_W-1:0] min_sum;
        time_field_t      hr_next;
        time_field_t      min_next;
        min_sum  = {1'b0, minutes} + {1'b0, delta};
        hr_next  = hours;
        min_next = min_sum[TIME_W-1:0];
        if (min_sum >= SUM_W'(MINUTES_PER_HOUR)) begin
            min_next = TIME_W'(min_sum - SUM_W'(MINUTES_PER_HOUR));
            hr_next  = hours + TIME_W'(1);
        end
        if (hr_next >= TIME_W'(HOURS_PER_DAY)) begin
            hr_next = '0;
        end
        return {hr_next, min_next};
    endfunction

endpackage

// File: rtl/multi_alarm_controller_if.sv
// Bus between the timekeeping/alarm-set side and the alarm controller.
interface multi_alarm_controller_if #(
    parameter int unsigned NUM_ALARMS = 4
) ();
    import alarm_pkg::*;

    time_field_t                  clockMinutes;
    time_field_t                  clockHours;
    logic [TIME_W*NUM_ALARMS-1:0] alarmMinutes;
    logic [TIME_W*NUM_ALARMS-1:0] alarmHours;
    logic [NUM_ALARMS-1:0]        enable;
    logic                         snooze;
    logic                         dismiss;
    logic                         clk2s;
    logic                         alarmOn;
    logic [NUM_ALARMS-1:0]        ringing;
    logic [NUM_ALARMS-1:0]        snoozed;

    modport master (
        output clockMinutes, clockHours, alarmMinutes, alarmHours, enable, snooze, dismiss, clk2s,
        input  alarmOn, ringing, snoozed
    );

    modport slave (
        input  clockMinutes, clockHours, alarmMinutes, alarmHours, enable, snooze, dismiss, clk2s,
        output alarmOn, ringing, snoozed
    );

endinterface

// File: rtl/alarm_channel.sv
// One alarm channel: match edge detect, snooze target, snooze/timeout counters and FSM.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN  = 9,
    parameter int unsigned TIMEOUT_MIN = 10,
    parameter int unsigned MAX_SNOOZES = 3
) (
    input  logic        clk5MHz,
    input  logic        reset,
    input  time_field_t clockMinutes,
    input  time_field_t clockHours,
    input  time_field_t alarmMinutes,
    input  time_field_t alarmHours,
    input  logic        enable,
    input  logic        snooze,
    input  logic        dismiss,
    input  logic        tick,
    output logic        ringing,
    output logic        snoozed
);

    localparam time_field_t SnoozeDelta = TIME_W'(SNOOZE_MIN);
    localparam logic [5:0]  TimeoutLast = 6'(TIMEOUT_MIN - 1);
    localparam logic [2:0]  SnoozeLimit = 3'(MAX_SNOOZES);

    alarm_state_e state_q, state_d;
    logic         prev_match_q, prev_tmatch_q;
    logic [2:0]   snooze_cnt_q, snooze_cnt_d;
    logic [5:0]   timeout_cnt_q, timeout_cnt_d;
    time_field_t  target_hr_q, target_hr_d;
    time_field_t  target_min_q, target_min_d;
    logic         match, tmatch, trigger, target_hit, timeout;

    assign match      = (clockMinutes == alarmMinutes) && (clockHours == alarmHours);
    assign tmatch     = (clockMinutes == target_min_q) && (clockHours == target_hr_q);
    assign trigger    = match & ~prev_match_q;
    assign target_hit = tmatch & ~prev_tmatch_q;
    // Fires on the tick that would bring the count to TIMEOUT_MIN.
    assign timeout    = tick && (timeout_cnt_q >= TimeoutLast);

    // Next-state logic; priority enable low > dismiss > timeout > snooze > trigger.
    always_comb begin
        state_d       = state_q;
        snooze_cnt_d  = snooze_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        target_hr_d   = target_hr_q;
        target_min_d  = target_min_q;
        case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d       = StRinging;
                    snooze_cnt_d  = '0;
                    timeout_cnt_d = '0;
                end
            end
            StRinging: begin
                if (dismiss || timeout) begin
                    state_d = StIdle;
                end else if (snooze) begin
                    if (snooze_cnt_q < SnoozeLimit) begin
                        state_d       = StSnoozed;
                        snooze_cnt_d  = snooze_cnt_q + 3'd1;
                        timeout_cnt_d = '0;
                        {target_hr_d, target_min_d} = time_add(clockHours, clockMinutes,
                                                               SnoozeDelta);
                    end else begin
                        state_d = StIdle;
                    end
                end else if (tick && (timeout_cnt_q != '1)) begin
                    timeout_cnt_d = timeout_cnt_q + 6'd1;
                end
            end
            StSnoozed: begin
                if (dismiss) begin
                    state_d = StIdle;
                end else if (target_hit) begin
                    state_d = StRinging;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!enable) begin
            state_d = StIdle;
        end
    end

    // State, counters, target and edge-detect history.
    always_ff @(posedge clk5MHz or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            prev_match_q  <= 1'b0;
            prev_tmatch_q <= 1'b0;
            snooze_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            target_hr_q   <= '0;
            target_min_q  <= '0;
        end else begin
            state_q       <= state_d;
            prev_match_q  <= match;
            prev_tmatch_q <= tmatch;
            snooze_cnt_q  <= snooze_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            target_hr_q   <= target_hr_d;
            target_min_q  <= target_min_d;
        end
    end

    assign ringing = (state_q == StRinging);
    assign snoozed = (state_q == StSnoozed);

endmodule

// File: rtl/multi_alarm_controller.sv
// Multi-channel alarm controller: minute tick, per-channel FSMs and gated buzzer output.
// NUM_ALARMS must match the parameter of the connected bus interface.
module multi_alarm_controller
    import alarm_pkg::*;
#(
    parameter int unsigned NUM_ALARMS  = 4,
    parameter int unsigned SNOOZE_MIN  = 9,
    parameter int unsigned TIMEOUT_MIN = 10,
    parameter int unsigned MAX_SNOOZES = 3
) (
    input logic                     clk5MHz,
    input logic                     reset,
    multi_alarm_controller_if.slave bus
);

    time_field_t           minute_q;
    logic                  tick;
    logic                  alarm_on_q;
    logic [NUM_ALARMS-1:0] ringing_vec;
    logic [NUM_ALARMS-1:0] snoozed_vec;

    assign tick = (bus.clockMinutes != minute_q);

    // Minute copy for tick detection and registered buzzer gate.
    always_ff @(posedge clk5MHz or posedge reset) begin
        if (reset) begin
            minute_q   <= '0;
            alarm_on_q <= 1'b0;
        end else begin
            minute_q   <= bus.clockMinutes;
            alarm_on_q <= bus.clk2s & (|ringing_vec);
        end
    end

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_channel
        alarm_channel #(
            .SNOOZE_MIN  (SNOOZE_MIN),
            .TIMEOUT_MIN (TIMEOUT_MIN),
            .MAX_SNOOZES (MAX_SNOOZES)
        ) u_channel (
            .clk5MHz      (clk5MHz),
            .reset        (reset),
            .clockMinutes (bus.clockMinutes),
            .clockHours   (bus.clockHours),
            .alarmMinutes (bus.alarmMinutes[TIME_W*i +: TIME_W]),
            .alarmHours   (bus.alarmHours[TIME_W*i +: TIME_W]),
            .enable       (bus.enable[i]),
            .snooze       (bus.snooze),
            .dismiss      (bus.dismiss),
            .tick         (tick),
            .ringing      (ringing_vec[i]),
            .snoozed      (snoozed_vec[i])
        );
    end

    assign bus.alarmOn = alarm_on_q;
    assign bus.ringing = ringing_vec;
    assign bus.snoozed = snoozed_vec;

endmodule

// File: tb/tb_multi_alarm_controller.sv
// Bench for multi_alarm_controller: directed scenarios plus random stimulus against a
// minute-of-day reference model.
module tb_multi_alarm_controller;

    localparam int unsigned NA = 4;
    localparam int SNZ  = 9;
    localparam int TMO  = 10;
    localparam int MAXS = 3;
    localparam int DAY  = 1440;
    localparam int IDLE = 0;
    localparam int RING = 1;
    localparam int SNOOZE = 2;

    logic clk5MHz = 1'b0;
    logic reset;

    multi_alarm_controller_if #(.NUM_ALARMS(NA)) bus ();

    multi_alarm_controller #(
        .NUM_ALARMS  (NA),
        .SNOOZE_MIN  (SNZ),
        .TIMEOUT_MIN (TMO),
        .MAX_SNOOZES (MAXS)
    ) dut (
        .clk5MHz (clk5MHz),
        .reset   (reset),
        .bus     (bus)
    );

    always #100 clk5MHz = ~clk5MHz;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus state (times as minute of day).
    int            now_min;
    int            al[NA];
    logic [NA-1:0] en;

    // Reference model state.
    int m_st[NA];
    int m_snz[NA];
    int m_ticks[NA];
    int m_tgt[NA];
    bit m_prev[NA];
    bit m_tprev[NA];
    int m_last;
    bit m_on;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_vec(input int st);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NA; i++) if (m_st[i] == st) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            m_st[i] = IDLE; m_snz[i] = 0; m_ticks[i] = 0; m_tgt[i] = 0;
            m_prev[i] = 1'b0; m_tprev[i] = 1'b0;
        end
        m_last = 0;
        m_on   = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit d, input bit c2s);
        bit tick;
        bit any_ring;
        tick = ((now_min % 60) != m_last);
        any_ring = 1'b0;
        for (int i = 0; i < NA; i++) if (m_st[i] == RING) any_ring = 1'b1;
        m_on = c2s && any_ring;
        for (int i = 0; i < NA; i++) begin
            bit mt;
            bit tm;
            bit trig;
            bit hit;
            mt   = (now_min == al[i]);
            tm   = (now_min == m_tgt[i]);
            trig = mt && !m_prev[i];
            hit  = tm && !m_tprev[i];
            m_prev[i]  = mt;
            m_tprev[i] = tm;
            if (!en[i]) begin
                m_st[i] = IDLE;
            end else if (m_st[i] == IDLE) begin
                if (trig) begin
                    m_st[i] = RING; m_snz[i] = 0; m_ticks[i] = 0;
                end
            end else if (m_st[i] == RING) begin
                if (d) m_st[i] = IDLE;
                else if (tick && (m_ticks[i] + 1 >= TMO)) m_st[i] = IDLE;
                else if (s) begin
                    if (m_snz[i] < MAXS) begin
                        m_st[i]    = SNOOZE;
                        m_snz[i]   = m_snz[i] + 1;
                        m_ticks[i] = 0;
                        m_tgt[i]   = (now_min + SNZ) % DAY;
                    end else begin
                        m_st[i] = IDLE;
                    end
                end else if (tick) m_ticks[i] = m_ticks[i] + 1;
            end else begin
                if (d) m_st[i] = IDLE;
                else if (hit) m_st[i] = RING;
            end
        end
        m_last = now_min % 60;
    endtask

    task automatic drive_inputs();
        bus.clockHours   = 6'(now_min / 60);
        bus.clockMinutes = 6'(now_min % 60);
        for (int i = 0; i < NA; i++) begin
            bus.alarmHours[6*i +: 6]   = 6'(al[i] / 60);
            bus.alarmMinutes[6*i +: 6] = 6'(al[i] % 60);
        end
        bus.enable = en;
    endtask

    task automatic step(input bit s, input bit d);
        bit c2s;
        c2s = 1'($urandom_range(1, 0));
        bus.snooze  = s;
        bus.dismiss = d;
        bus.clk2s   = c2s;
        drive_inputs();
        @(posedge clk5MHz);
        model_edge(s, d, c2s);
        #1;
        check("ringing", 32'(bus.ringing), exp_vec(RING));
        check("snoozed", 32'(bus.snoozed), exp_vec(SNOOZE));
        check("alarmOn", 32'(bus.alarmOn), 32'(m_on));
        bus.snooze  = 1'b0;
        bus.dismiss = 1'b0;
    endtask

    task automatic advance(input int mins, input int per_min);
        for (int k = 0; k < mins; k++) begin
            now_min = (now_min + 1) % DAY;
            repeat (per_min) step(1'b0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        now_min = 0;
        en = '0;
        for (int i = 0; i < NA; i++) al[i] = 0;
        bus.snooze = 1'b0;
        bus.dismiss = 1'b0;
        bus.clk2s = 1'b0;
        drive_inputs();
        model_reset();
        #50;
        check("rst_ringing", 32'(bus.ringing), 32'h0);
        check("rst_snoozed", 32'(bus.snoozed), 32'h0);
        check("rst_alarmOn", 32'(bus.alarmOn), 32'h0);
        @(negedge clk5MHz);
        reset = 1'b0;

        // Basic trigger, alarmOn tracking and dismiss without retrigger.
        en = 4'b0001;
        al[0] = 7 * 60 + 30;
        now_min = 7 * 60 + 29;
        repeat (2) step(1'b0, 1'b0);
        now_min = 7 * 60 + 30;
        step(1'b0, 1'b0);
        check("s1_ring", 32'(bus.ringing[0]), 32'h1);
        repeat (4) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("s1_dismiss", 32'(bus.ringing[0]), 32'h0);
        repeat (3) step(1'b0, 1'b0);
        check("s1_noretrig", 32'(bus.ringing[0]), 32'h0);

        // Snooze across midnight, re-ring, snooze limit.
        al[0] = 23 * 60 + 55;
        now_min = 23 * 60 + 54;
        step(1'b0, 1'b0);
        now_min = 23 * 60 + 55;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("s2_snoozed", 32'(bus.snoozed[0]), 32'h1);
        advance(8, 1);
        check("s2_before_tgt", 32'(bus.ringing[0]), 32'h0);
        advance(1, 1);
        check("s2_rering", 32'(bus.ringing[0]), 32'h1);
        check("s2_tgt_time", 32'(now_min), 32'd4);
        step(1'b1, 1'b0);
        advance(9, 1);
        check("s3_ring2", 32'(bus.ringing[0]), 32'h1);
        step(1'b1, 1'b0);
        advance(9, 1);
        check("s3_ring3", 32'(bus.ringing[0]), 32'h1);
        step(1'b1, 1'b0);
        check("s3_fourth_ring", 32'(bus.ringing[0]), 32'h0);
        check("s3_fourth_snz", 32'(bus.snoozed[0]), 32'h0);

        // Ring timeout with no user input.
        al[0] = 10 * 60;
        now_min = 9 * 60 + 59;
        step(1'b0, 1'b0);
        now_min = 10 * 60;
        step(1'b0, 1'b0);
        advance(9, 2);
        check("s4_before_to", 32'(bus.ringing[0]), 32'h1);
        advance(1, 1);
        check("s4_timeout", 32'(bus.ringing[0]), 32'h0);
        step(1'b0, 1'b0);
        check("s4_alarm_off", 32'(bus.alarmOn), 32'h0);

        // Two channels, shared dismiss, per-channel enable.
        en = 4'b0101;
        al[0] = 6 * 60;
        al[2] = 6 * 60;
        now_min = 5 * 60 + 59;
        step(1'b0, 1'b0);
        now_min = 6 * 60;
        step(1'b0, 1'b0);
        check("s5_both", 32'(bus.ringing), 32'h5);
        step(1'b0, 1'b1);
        check("s5_dismiss", 32'(bus.ringing), 32'h0);
        al[0] = 6 * 60 + 2;
        al[2] = 6 * 60 + 2;
        advance(2, 1);
        check("s5_both2", 32'(bus.ringing), 32'h5);
        en[2] = 1'b0;
        step(1'b0, 1'b0);
        check("s5_en_low", 32'(bus.ringing), 32'h1);

        // Asynchronous reset while snoozed with snooze and dismiss asserted.
        en = 4'b0001;
        step(1'b0, 1'b1);
        al[0] = 12 * 60;
        now_min = 11 * 60 + 59;
        step(1'b0, 1'b0);
        now_min = 12 * 60;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("s6_snoozed", 32'(bus.snoozed[0]), 32'h1);
        #20;
        bus.snooze = 1'b1;
        bus.dismiss = 1'b1;
        reset = 1'b1;
        #1;
        check("s6_async_ring", 32'(bus.ringing), 32'h0);
        check("s6_async_snz", 32'(bus.snoozed), 32'h0);
        check("s6_async_on", 32'(bus.alarmOn), 32'h0);
        model_reset();
        now_min = 12 * 60 + 1;
        drive_inputs();
        repeat (2) @(posedge clk5MHz);
        @(negedge clk5MHz);
        reset = 1'b0;
        bus.snooze = 1'b0;
        bus.dismiss = 1'b0;
        repeat (5) step(1'b0, 1'b0);
        check("s6_quiet", 32'(bus.ringing), 32'h0);
        now_min = 12 * 60;
        step(1'b0, 1'b0);
        check("s6_next_edge", 32'(bus.ringing[0]), 32'h1);

        // Random phase.
        en = 4'b1111;
        for (int k = 0; k < 3000; k++) begin
            if (k % 150 == 0) begin
                for (int i = 0; i < NA; i++) al[i] = (now_min + int'($urandom_range(6, 1))) % DAY;
            end
            if ($urandom_range(99, 0) < 25) now_min = (now_min + 1) % DAY;
            if ($urandom_range(199, 0) == 0) begin
                int unsigned idx;
                idx = $urandom_range(NA - 1, 0);
                en[idx] = ~en[idx];
            end
            step($urandom_range(29, 0) == 0, $urandom_range(59, 0) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
